// File: rtl/regfile_dump_if.sv
// Byte-stream port of the register-file dump engine (valid/ready).
// master: the dump engine; slave: the debug UART/JTAG sink.
interface regfile_dump_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine for the register file.
// Sends a header byte, then every register (low byte first) through a
// spare read port, then the 9-bit flags as two bytes, on a valid/ready port.
// Optional feature macro: REGFILE_DUMP_CKSUM_EN appends an 8-bit running sum
// of all transferred bytes (header included) before completion.
module regfile_dump #(
  parameter int unsigned NREGS = 16,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [3:0]            rd_addr,
  input  logic [15:0]           rd_data,
  input  logic [8:0]            flags_i,
  regfile_dump_if.master        tx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_LO,
    S_HI,
    S_FLO,
    S_FHI,
`ifdef REGFILE_DUMP_CKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  idx;
  logic [15:0] wbuf;
  logic [8:0]  flags_q;
  logic        xfer;
  logic        idx_last;
`ifdef REGFILE_DUMP_CKSUM_EN
  logic [7:0]  cksum;
`endif

  // abort wins over a simultaneous handshake: that byte is not accepted
  assign xfer     = tx.tx_valid & tx.tx_ready & ~abort;
  assign idx_last = (idx == 5'(NREGS - 1));
  assign rd_addr  = idx[3:0];
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and byte-port drive; tx_data is a pure function of
  // state and snapshot registers, so it stays stable until accepted
  always_comb begin
    state_nxt   = state;
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    case (state)
      S_IDLE: begin
        if (start && !abort) state_nxt = S_HDR;
      end
      S_HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = HDR;
        if (tx.tx_ready) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_LO;
      end
      S_LO: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = wbuf[7:0];
        if (tx.tx_ready) state_nxt = S_HI;
      end
      S_HI: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = wbuf[15:8];
        if (tx.tx_ready) state_nxt = idx_last ? S_FLO : S_LOAD;
      end
      S_FLO: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = flags_q[7:0];
        if (tx.tx_ready) state_nxt = S_FHI;
      end
      S_FHI: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = {7'b0, flags_q[8]};
`ifdef REGFILE_DUMP_CKSUM_EN
        if (tx.tx_ready) state_nxt = S_CSUM;
`else
        if (tx.tx_ready) state_nxt = S_DONE;
`endif
      end
`ifdef REGFILE_DUMP_CKSUM_EN
      S_CSUM: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = cksum;
        if (tx.tx_ready) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

  // Datapath: register index, word snapshot, flags snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      wbuf    <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (start && !abort) flags_q <= flags_i;
        end
        S_LOAD: begin
          wbuf <= rd_data;
        end
        S_HI: begin
          if (xfer) idx <= idx + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef REGFILE_DUMP_CKSUM_EN
  // Running byte sum of everything accepted before the checksum byte itself
  always_ff @(posedge clk) begin
    if (rst) begin
      cksum <= '0;
    end else if (state == S_IDLE) begin
      cksum <= '0;
    end else if (xfer && state != S_CSUM) begin
      cksum <= cksum + tx.tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump (NREGS=16, HDR=8'hA5).
module tb_regfile_dump;

`ifdef REGFILE_DUMP_CKSUM_EN
  localparam int DONE_CYC = 53;
  localparam int NBYTES   = 36;
`else
  localparam int DONE_CYC = 52;
  localparam int NBYTES   = 35;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [8:0]  flags_i = '0;
  logic        busy;
  logic        done;
  logic [15:0] regs [16];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int done_at     = 0;
  int s0          = 0;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];

  regfile_dump_if bus();

  assign rd_data = regs[rd_addr];

  regfile_dump #(.NREGS(16), .HDR(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .flags_i (flags_i),
    .tx      (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink monitor sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && !abort && bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    if (done) begin
      done_cnt = done_cnt + 1;
      done_at  = cyc;
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task fill_ramp;
    for (int i = 0; i < 16; i++) regs[i] = 16'((32'h1100 * i) + i);
  endtask

  task fill_zero;
    for (int i = 0; i < 16; i++) regs[i] = '0;
  endtask

  task build_expected;
    logic [7:0] sum;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(regs[i][7:0]);
      exp_q.push_back(regs[i][15:8]);
    end
    exp_q.push_back(flags_i[7:0]);
    exp_q.push_back({7'b0, flags_i[8]});
`ifdef REGFILE_DUMP_CKSUM_EN
    sum = '0;
    foreach (exp_q[i]) sum = sum + exp_q[i];
    exp_q.push_back(sum);
`else
    sum = '0;
`endif
  endtask

  task start_dump;
    got.delete();
    done_cnt = 0;
    start = 1'b1;
    s0 = cyc;
    tick;
    start = 1'b0;
  endtask

  task wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick;
  endtask

  task test_reset;
    rst = 1'b1;
    tick;
    tick;
    vectors++; if (rd_addr !== 4'h0) begin miscompares++; $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %0h expected 0", bus.tx_data); end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %0b expected 0", bus.tx_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", done); end
    rst = 1'b0;
    tick;
  endtask

  task test_full;
    logic [7:0] g;
    fill_ramp;
    flags_i = 9'h1C5;
    bus.tx_ready = 1'b1;
    build_expected;
    start_dump;
    vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin miscompares++; $display("FAIL full_hdr_cycle1: got v=%0b d=%0h expected v=1 d=a5", bus.tx_valid, bus.tx_data); end
    wait_done(120);
    tick;
    tick;
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
    vectors++; if (done_at - s0 !== DONE_CYC) begin miscompares++; $display("FAIL full_done_cycle: got %0d expected %0d", done_at - s0, DONE_CYC); end
    vectors++; if (got.size() !== NBYTES) begin miscompares++; $display("FAIL full_byte_count: got %0d expected %0d", got.size(), NBYTES); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      vectors++;
      if (g !== exp_q[i]) begin miscompares++; $display("FAIL full_byte[%0d]: got %0h expected %0h", i, g, exp_q[i]); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_after: got %0b expected 0", busy); end
  endtask

  task test_stall;
    logic [7:0] g;
    fill_ramp;
    flags_i = 9'h1C5;
    bus.tx_ready = 1'b1;
    build_expected;
    start_dump;
    while (cyc - s0 < 7) tick;
    bus.tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++; if (bus.tx_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %0b expected 1", k, bus.tx_valid); end
      vectors++; if (bus.tx_data !== 8'h11) begin miscompares++; $display("FAIL stall_data[%0d]: got %0h expected 11", k, bus.tx_data); end
      tick;
    end
    bus.tx_ready = 1'b1;
    wait_done(120);
    tick;
    vectors++; if (done_at - s0 !== DONE_CYC + 5) begin miscompares++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_at - s0, DONE_CYC + 5); end
    vectors++; if (got.size() !== NBYTES) begin miscompares++; $display("FAIL stall_byte_count: got %0d expected %0d", got.size(), NBYTES); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      vectors++;
      if (g !== exp_q[i]) begin miscompares++; $display("FAIL stall_byte[%0d]: got %0h expected %0h", i, g, exp_q[i]); end
    end
  endtask

  task test_abort;
    fill_ramp;
    flags_i = 9'h1C5;
    bus.tx_ready = 1'b1;
    start_dump;
    while (cyc - s0 < 25) tick;
    vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h77) begin miscompares++; $display("FAIL abort_in_hi7: got v=%0b d=%0h expected v=1 d=77", bus.tx_valid, bus.tx_data); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL abort_tx_valid: got %0b expected 0", bus.tx_valid); end
    for (int k = 0; k < 5; k++) tick;
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    vectors++; if (got.size() !== 16) begin miscompares++; $display("FAIL abort_bytes_sent: got %0d expected 16", got.size()); end
    start_dump;
    vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin miscompares++; $display("FAIL abort_restart_hdr: got v=%0b d=%0h expected v=1 d=a5", bus.tx_valid, bus.tx_data); end
    wait_done(120);
    tick;
    vectors++; if (got.size() !== NBYTES) begin miscompares++; $display("FAIL abort_restart_count: got %0d expected %0d", got.size(), NBYTES); end
  endtask

  task test_start_ignored;
    int c;
    fill_ramp;
    flags_i = 9'h1C5;
    bus.tx_ready = 1'b1;
    start_dump;
    while (cyc - s0 < DONE_CYC + 6) begin
      c = cyc - s0;
      start = (c == 5 || c == 20 || c == DONE_CYC);
      tick;
    end
    start = 1'b0;
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt); end
    vectors++; if (got.size() !== NBYTES) begin miscompares++; $display("FAIL ign_byte_count: got %0d expected %0d", got.size(), NBYTES); end
    vectors++; if (done_at - s0 !== DONE_CYC) begin miscompares++; $display("FAIL ign_done_cycle: got %0d expected %0d", done_at - s0, DONE_CYC); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ign_busy_after_done: got %0b expected 0", busy); end
  endtask

  task test_zero;
    logic [7:0] last_exp;
    fill_zero;
    flags_i = '0;
    bus.tx_ready = 1'b1;
`ifdef REGFILE_DUMP_CKSUM_EN
    last_exp = 8'hA5;
`else
    last_exp = 8'h00;
`endif
    start_dump;
    wait_done(120);
    tick;
    vectors++; if (got.size() !== NBYTES) begin miscompares++; $display("FAIL zero_byte_count: got %0d expected %0d", got.size(), NBYTES); end
    vectors++; if (got.size() == 0 || got[got.size() - 1] !== last_exp) begin miscompares++; $display("FAIL zero_last_byte: got %0h expected %0h", (got.size() == 0) ? 8'hxx : got[got.size() - 1], last_exp); end
    vectors++; if (done_at - s0 !== DONE_CYC) begin miscompares++; $display("FAIL zero_done_cycle: got %0d expected %0d", done_at - s0, DONE_CYC); end
  endtask

  task test_rst_mid;
    fill_ramp;
    flags_i = 9'h1C5;
    bus.tx_ready = 1'b1;
    start_dump;
    while (cyc - s0 < 10) tick;
    rst = 1'b1;
    tick;
    vectors++; if (rd_addr !== 4'h0) begin miscompares++; $display("FAIL rstmid_rd_addr: got %0h expected 0", rd_addr); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_tx_data: got %0h expected 0", bus.tx_data); end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_tx_valid: got %0b expected 0", bus.tx_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %0b expected 0", done); end
    rst = 1'b0;
    for (int k = 0; k < 60; k++) tick;
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy_later: got %0b expected 0", busy); end
  endtask

  task test_start_abort_idle;
    done_cnt = 0;
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_start_abort_busy: got %0b expected 0", busy); end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL idle_start_abort_valid: got %0b expected 0", bus.tx_valid); end
    tick;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_start_abort_busy2: got %0b expected 0", busy); end
  endtask

  initial begin
    bus.tx_ready = 1'b1;
    fill_zero;
    test_reset;
    test_full;
    test_stall;
    test_abort;
    test_start_ignored;
    test_zero;
    test_rst_mid;
    test_start_abort_idle;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
